// File: rtl/print_ammo_hud.sv
// Ammo HUD: tracks a magazine (fire / reload FSM) and paints one row of
// bullet slots into the pixel stream with a one-clock registered colour.
//
// Handshake: fire is a level sampled every clock. A shot is accepted on a
// clock edge where the FSM is READY, fire is high and at least one bullet is
// left. Each accepted shot produces exactly one fire_ack cycle, which
// coincides with the decremented left_bullet. There is no ready/stall on
// fire: a rejected shot is simply dropped. reload_req is likewise a sampled
// level with no acknowledge; the reloading output reflects the FSM state.
module print_ammo_hud #(
    parameter int          MAX_BULLETS   = 6,
    parameter int          BULLET_HW     = 10,
    parameter int          BULLET_HH     = 20,
    parameter int          ORIGIN_X      = 320,
    parameter int          ORIGIN_Y      = 450,
    parameter int          GAP           = 40,
    parameter int          RELOAD_FRAMES = 8,
    parameter int          BLINK_FRAMES  = 16,
    parameter logic [9:0]  VGA_RGB_NULL  = 10'h400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  px,
    input  logic [9:0]  py,
    input  logic        frame_tick,
    input  logic        fire,
    input  logic        reload_req,
    output logic [9:0]  r,
    output logic [9:0]  g,
    output logic [9:0]  b,
    output logic        isPrinted,
    output logic [3:0]  left_bullet,
    output logic        reloading,
    output logic        fire_ack
);

    typedef enum logic {READY = 1'b0, RELOADING = 1'b1} state_t;

    localparam logic [3:0]  MAX4   = 4'(MAX_BULLETS);
    localparam logic [15:0] RLAST  = 16'(RELOAD_FRAMES - 1);
    localparam logic [15:0] BLAST  = 16'(BLINK_FRAMES - 1);
    localparam logic [15:0] HW16   = 16'(BULLET_HW);
    localparam logic [15:0] HH16   = 16'(BULLET_HH);
    localparam logic [15:0] OY16   = 16'(ORIGIN_Y);

    state_t      state_q, state_d;
    logic [3:0]  left_q, left_d;
    logic [15:0] rcnt_q, rcnt_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic        blink_on_q, blink_on_d;
    logic        fire_ack_q, fire_ack_d;
    logic [9:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        printed_q, printed_d;

    // Magazine FSM: fire beats reload in READY; RELOADING refills one bullet
    // per RELOAD_FRAMES frame ticks and exits on the edge it becomes full.
    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        rcnt_d     = rcnt_q;
        fire_ack_d = 1'b0;
        case (state_q)
            READY: begin
                if (fire) begin
                    if (left_q != 4'd0) begin
                        left_d     = left_q - 4'd1;
                        fire_ack_d = 1'b1;
                    end
                end else if (reload_req && left_q != MAX4) begin
                    state_d = RELOADING;
                    rcnt_d  = '0;
                end
            end
            RELOADING: begin
                if (frame_tick) begin
                    if (rcnt_q == RLAST) begin
                        rcnt_d = '0;
                        left_d = left_q + 4'd1;
                        if (left_q + 4'd1 == MAX4) state_d = READY;
                    end else begin
                        rcnt_d = rcnt_q + 16'd1;
                    end
                end
            end
            default: state_d = READY;
        endcase
    end

    // Free-running blink divider: phase flips every BLINK_FRAMES ticks.
    always_comb begin
        bcnt_d     = bcnt_q;
        blink_on_d = blink_on_q;
        if (frame_tick) begin
            if (bcnt_q == BLAST) begin
                bcnt_d     = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                bcnt_d = bcnt_q + 16'd1;
            end
        end
    end

    // Pixel colour from the slot hit test against the current (pre-update)
    // state; compares are done in 16 bits so edge slots cannot wrap.
    logic [15:0] px_w, py_w, cx;
    logic        y_in, in_slot, hit_cur, hit_next, hit_first;
    always_comb begin
        px_w      = {6'd0, px};
        py_w      = {6'd0, py};
        cx        = '0;
        in_slot   = 1'b0;
        hit_cur   = 1'b0;
        hit_next  = 1'b0;
        hit_first = 1'b0;
        y_in      = (py_w + HH16 >= OY16) && (py_w <= OY16 + HH16);
        for (int i = 1; i <= MAX_BULLETS; i++) begin
            cx      = 16'(ORIGIN_X + GAP * i);
            in_slot = y_in && (px_w + HW16 >= cx) && (px_w <= cx + HW16);
            if (in_slot && (4'(i) <= left_q)) hit_cur = 1'b1;
            if (in_slot && (5'(i) == {1'b0, left_q} + 5'd1)) hit_next = 1'b1;
            if (in_slot && (i == 1)) hit_first = 1'b1;
        end
        r_d = VGA_RGB_NULL;
        g_d = VGA_RGB_NULL;
        b_d = VGA_RGB_NULL;
        if (hit_cur) begin
            r_d = 10'h2cc; g_d = 10'h2cc; b_d = 10'h066;
        end else if (hit_next && state_q == RELOADING) begin
            r_d = 10'h155; g_d = 10'h155; b_d = 10'h155;
        end else if (hit_first && state_q == READY && left_q == 4'd0 && blink_on_q) begin
            r_d = 10'h3ff; g_d = 10'h000; b_d = 10'h000;
        end
        printed_d = (r_d != VGA_RGB_NULL) || (g_d != VGA_RGB_NULL) || (b_d != VGA_RGB_NULL);
    end

    // State and output registers; reset drops any reload in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= READY;
            left_q     <= MAX4;
            rcnt_q     <= '0;
            bcnt_q     <= '0;
            blink_on_q <= 1'b1;
            fire_ack_q <= 1'b0;
            r_q        <= VGA_RGB_NULL;
            g_q        <= VGA_RGB_NULL;
            b_q        <= VGA_RGB_NULL;
            printed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            rcnt_q     <= rcnt_d;
            bcnt_q     <= bcnt_d;
            blink_on_q <= blink_on_d;
            fire_ack_q <= fire_ack_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            printed_q  <= printed_d;
        end
    end

    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign isPrinted   = printed_q;
    assign left_bullet = left_q;
    assign reloading   = (state_q == RELOADING);
    assign fire_ack    = fire_ack_q;

endmodule

// File: tb/tb_print_ammo_hud.sv
// Directed bench for print_ammo_hud: a vector table for the single-cycle
// behaviour plus hand-written reload, reset-abort and blink sequences.
module tb_print_ammo_hud;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  px = '0, py = 10'd450;
    logic        frame_tick = 1'b0, fire = 1'b0, reload_req = 1'b0;
    logic [9:0]  r, g, b;
    logic        isPrinted;
    logic [3:0]  left_bullet;
    logic        reloading, fire_ack;

    int checks = 0;
    int errors = 0;

    localparam int C_NULL = 0, C_YEL = 1, C_GRY = 2, C_RED = 3;

    typedef struct {
        logic [9:0] px, py;
        logic       fire, reload;
        int         col;
        logic [3:0] left;
        logic       rel, ack;
    } vec_t;
    vec_t tbl[$];

    print_ammo_hud dut (
        .clk(clk), .rst_n(rst_n), .px(px), .py(py), .frame_tick(frame_tick),
        .fire(fire), .reload_req(reload_req), .r(r), .g(g), .b(b),
        .isPrinted(isPrinted), .left_bullet(left_bullet), .reloading(reloading),
        .fire_ack(fire_ack)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] pix(input int col);
        case (col)
            C_YEL:   pix = {1'b0, 10'h2cc, 10'h2cc, 10'h066, 1'b1};
            C_GRY:   pix = {1'b0, 10'h155, 10'h155, 10'h155, 1'b1};
            C_RED:   pix = {1'b0, 10'h3ff, 10'h000, 10'h000, 1'b1};
            default: pix = {1'b0, 10'h400, 10'h400, 10'h400, 1'b0};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_pix(input string nm, input int col);
        chk(nm, {1'b0, r, g, b, isPrinted}, pix(col));
    endtask

    // One clock; outputs are inspected 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [9:0] x, input logic [9:0] y,
                         input logic f, input logic rl, input logic t);
        px = x; py = y; fire = f; reload_req = rl; frame_tick = t;
        step();
        fire = 1'b0; reload_req = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic add(input int x, input int y, input logic f, input logic rl,
                       input int col, input int left, input logic rel, input logic ack);
        vec_t v;
        v.px = 10'(x); v.py = 10'(y); v.fire = f; v.reload = rl;
        v.col = col; v.left = 4'(left); v.rel = rel; v.ack = ack;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        fire = 1'b0; reload_req = 1'b0; frame_tick = 1'b0; px = '0; py = 10'd450;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int exp_left;
        // Reset values, checked while reset is held and before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk_pix("reset_pix", C_NULL);
        chk("reset_left", 32'(left_bullet), 32'd6);
        chk("reset_rel", 32'(reloading), 32'd0);
        chk("reset_ack", 32'(fire_ack), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Single-cycle vectors: inputs for one clock, then expected outputs
        add(360, 450, 0, 0, C_YEL, 6, 0, 0);
        add(0,   450, 0, 0, C_NULL, 6, 0, 0);
        add(350, 430, 0, 0, C_YEL, 6, 0, 0);
        add(349, 450, 0, 0, C_NULL, 6, 0, 0);
        add(370, 470, 0, 0, C_YEL, 6, 0, 0);
        add(360, 471, 0, 0, C_NULL, 6, 0, 0);
        add(560, 450, 0, 0, C_YEL, 6, 0, 0);
        add(571, 450, 0, 0, C_NULL, 6, 0, 0);
        add(560, 450, 1, 0, C_YEL, 5, 0, 1);
        add(560, 450, 0, 0, C_NULL, 5, 0, 0);
        add(520, 450, 1, 0, C_YEL, 4, 0, 1);
        add(520, 450, 0, 0, C_NULL, 4, 0, 0);
        add(480, 450, 1, 0, C_YEL, 3, 0, 1);
        add(480, 450, 0, 0, C_NULL, 3, 0, 0);
        add(440, 450, 1, 1, C_YEL, 2, 0, 1);
        add(440, 450, 0, 0, C_NULL, 2, 0, 0);
        add(0,   450, 1, 0, C_NULL, 1, 0, 1);
        add(0,   450, 1, 0, C_NULL, 0, 0, 1);
        add(0,   450, 1, 0, C_NULL, 0, 0, 0);
        add(360, 450, 0, 0, C_RED, 0, 0, 0);
        add(400, 450, 0, 0, C_NULL, 0, 0, 0);
        add(360, 450, 0, 1, C_RED, 0, 1, 0);
        add(360, 450, 0, 0, C_GRY, 0, 1, 0);
        add(360, 450, 1, 1, C_GRY, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].px, tbl[i].py, tbl[i].fire, tbl[i].reload, 1'b0);
            chk_pix($sformatf("vec%0d_pix", i), tbl[i].col);
            chk($sformatf("vec%0d_left", i), 32'(left_bullet), 32'(tbl[i].left));
            chk($sformatf("vec%0d_rel", i), 32'(reloading), 32'(tbl[i].rel));
            chk($sformatf("vec%0d_ack", i), 32'(fire_ack), 32'(tbl[i].ack));
        end

        // Full reload from empty: +1 every 8 ticks, grey slot follows count
        for (int t = 0; t < 48; t++) begin
            apply(10'd0, 10'd450, 1'b0, 1'b0, 1'b1);
            exp_left = (t + 1) / 8;
            if (exp_left < 6) begin
                apply(10'(360 + 40 * exp_left), 10'd450, 1'b0, 1'b0, 1'b0);
                chk_pix($sformatf("reload_t%0d_grey", t), C_GRY);
            end else begin
                apply(10'd560, 10'd450, 1'b0, 1'b0, 1'b0);
                chk_pix($sformatf("reload_t%0d_full", t), C_YEL);
            end
            chk($sformatf("reload_t%0d_left", t), 32'(left_bullet), 32'(exp_left));
            chk($sformatf("reload_t%0d_rel", t), 32'(reloading), 32'(exp_left < 6));
        end

        // Reset in the middle of a reload at count 2
        do_reset();
        for (int i = 0; i < 4; i++) apply(10'd0, 10'd450, 1'b1, 1'b0, 1'b0);
        apply(10'd0, 10'd450, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply(10'd0, 10'd450, 1'b0, 1'b0, 1'b1);
        apply(10'd360, 10'd450, 1'b0, 1'b0, 1'b0);
        chk_pix("abort_pre_pix", C_YEL);
        chk("abort_pre_left", 32'(left_bullet), 32'd2);
        chk("abort_pre_rel", 32'(reloading), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_pix("abort_pix", C_NULL);
        chk("abort_left", 32'(left_bullet), 32'd6);
        chk("abort_rel", 32'(reloading), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) apply(10'd0, 10'd450, 1'b0, 1'b0, 1'b1);
        apply(10'd360, 10'd450, 1'b0, 1'b0, 1'b0);
        chk_pix("abort_post_pix", C_YEL);
        chk("abort_post_left", 32'(left_bullet), 32'd6);
        chk("abort_post_rel", 32'(reloading), 32'd0);

        // Empty-magazine blink: 16 ticks red, 16 ticks null, repeating
        do_reset();
        for (int i = 0; i < 6; i++) apply(10'd0, 10'd450, 1'b1, 1'b0, 1'b0);
        apply(10'd360, 10'd450, 1'b0, 1'b0, 1'b0);
        chk_pix("blink_start", C_RED);
        for (int t = 0; t < 64; t++) begin
            apply(10'd0, 10'd450, 1'b0, 1'b0, 1'b1);
            apply(10'd360, 10'd450, 1'b0, 1'b0, 1'b0);
            chk_pix($sformatf("blink_t%0d", t), (((t + 1) / 16) % 2 == 0) ? C_RED : C_NULL);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
